safe_code_checker: RTL and testbench

//  Code datapath and attempt limiter next to the safe controller FSM. Consumes
//  its savePW/saveAT strobes, holds the stored password and latest attempt,
//  and drives MATCH back to it. Counts consecutive failed attempts. After
//  MAX_FAILS failures it enters a timed lockout that forces MATCH low.

---
 rtl/safe_code_checker.sv | 94 +++++++++
 tb/tb_safe_code_checker.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/safe_code_checker.sv
// Code datapath and consecutive-failure limiter for the safe controller: stores
// password/attempt, reports MATCH, and imposes a timed lockout after repeated failures.
module safe_code_checker #(
    parameter  int CODE_W         = 8,
    parameter  int MAX_FAILS      = 3,
    parameter  int LOCKOUT_CYCLES = 50_000_000,
    localparam int FC_W           = $clog2(MAX_FAILS + 1),
    localparam int TMR_W          = $clog2(LOCKOUT_CYCLES)
) (
    input  logic              clk,
    input  logic              RESET,
    input  logic [CODE_W-1:0] CODE_IN,
    input  logic              savePW,
    input  logic              saveAT,
    output logic              MATCH,
    output logic              LOCKOUT,
    output logic [FC_W-1:0]   FAIL_COUNT,
    output logic [1:0]        dbg_state_o
);

    // Handshake: savePW/saveAT are level strobes with no ready; every posedge
    // they are high captures CODE_IN, and an attempt ends on saveAT falling.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ATTEMPT = 2'd1,
        ST_LOCK    = 2'd2
    } state_e;

    state_e             state_q;
    logic [CODE_W-1:0]  pw_q;
    logic [CODE_W-1:0]  at_q;
    logic               pw_valid_q;
    logic               match_q;
    logic [FC_W-1:0]    fail_cnt_q;
    logic [TMR_W-1:0]   timer_q;

    assign LOCKOUT     = (state_q == ST_LOCK);
    assign MATCH       = pw_valid_q && (pw_q == at_q) && !LOCKOUT;
    assign FAIL_COUNT  = fail_cnt_q;
    assign dbg_state_o = state_q;

    always_ff @(posedge clk) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            pw_q       <= '0;
            at_q       <= '0;
            pw_valid_q <= 1'b0;
            match_q    <= 1'b0;
            fail_cnt_q <= '0;
            timer_q    <= '0;
        end else begin
            if (savePW) begin
                pw_q       <= CODE_IN;
                pw_valid_q <= 1'b1;
            end
            if (saveAT) begin
                at_q <= CODE_IN;
            end
            // Evaluation uses the MATCH the controller saw on its last strobe cycle.
            match_q <= MATCH;

            case (state_q)
                ST_IDLE: begin
                    if (saveAT) state_q <= ST_ATTEMPT;
                end
                ST_ATTEMPT: begin
                    if (!saveAT) begin
                        if (match_q) begin
                            fail_cnt_q <= '0;
                            state_q    <= ST_IDLE;
                        end else if (int'(fail_cnt_q) + 1 < MAX_FAILS) begin
                            fail_cnt_q <= fail_cnt_q + FC_W'(1);
                            state_q    <= ST_IDLE;
                        end else begin
                            fail_cnt_q <= FC_W'(MAX_FAILS);
                            timer_q    <= TMR_W'(LOCKOUT_CYCLES - 1);
                            state_q    <= ST_LOCK;
                        end
                    end
                end
                ST_LOCK: begin
                    if (timer_q == '0) begin
                        fail_cnt_q <= '0;
                        state_q    <= ST_IDLE;
                    end else begin
                        timer_q <= timer_q - TMR_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_safe_code_checker.sv
// Directed bench for safe_code_checker: capture, match, failure counting,
// lockout timing, lockout masking and reset abort.
module tb_safe_code_checker;

    localparam int CODE_W = 8;
    localparam int MAX_FAILS = 3;
    localparam int LOCKOUT_CYCLES = 5;
    localparam int FC_W = $clog2(MAX_FAILS + 1);

    logic              clk;
    logic              RESET;
    logic [CODE_W-1:0] CODE_IN;
    logic              savePW;
    logic              saveAT;
    logic              MATCH;
    logic              LOCKOUT;
    logic [FC_W-1:0]   FAIL_COUNT;
    logic [1:0]        dbg_state_o;

    int checks;
    int failures;

    safe_code_checker #(
        .CODE_W(CODE_W),
        .MAX_FAILS(MAX_FAILS),
        .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
    ) dut (
        .clk(clk),
        .RESET(RESET),
        .CODE_IN(CODE_IN),
        .savePW(savePW),
        .saveAT(saveAT),
        .MATCH(MATCH),
        .LOCKOUT(LOCKOUT),
        .FAIL_COUNT(FAIL_COUNT),
        .dbg_state_o(dbg_state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs are driven and outputs sampled 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pw(input logic [CODE_W-1:0] code, input int cycles);
        CODE_IN = code;
        savePW  = 1'b1;
        for (int i = 0; i < cycles; i++) step();
        savePW = 1'b0;
    endtask

    // Two-cycle attempt; MATCH checked while saveAT is still high, then saveAT falls.
    task automatic attempt(input logic [CODE_W-1:0] code, input logic exp_match, input string tag);
        CODE_IN = code;
        saveAT  = 1'b1;
        step();
        step();
        checks++;
        if (MATCH !== exp_match) begin
            failures++;
            $display("FAIL %s match: got %b expected %b", tag, MATCH, exp_match);
        end
        saveAT = 1'b0;
        step();
    endtask

    task automatic expect_fc(input logic [FC_W-1:0] exp, input string tag);
        checks++;
        if (FAIL_COUNT !== exp) begin
            failures++;
            $display("FAIL %s fail_count: got %0d expected %0d", tag, FAIL_COUNT, exp);
        end
    endtask

    task automatic expect_lock(input logic exp, input string tag);
        checks++;
        if (LOCKOUT !== exp) begin
            failures++;
            $display("FAIL %s lockout: got %b expected %b", tag, LOCKOUT, exp);
        end
    endtask

    task automatic expect_match(input logic exp, input string tag);
        checks++;
        if (MATCH !== exp) begin
            failures++;
            $display("FAIL %s match: got %b expected %b", tag, MATCH, exp);
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        step();
        step();
        RESET = 1'b0;
        expect_match(1'b0, "reset");
        expect_lock(1'b0, "reset");
        expect_fc(2'd0, "reset");
        checks++;
        if (dbg_state_o !== 2'd0) begin
            failures++;
            $display("FAIL reset state: got %0d expected 0", dbg_state_o);
        end
    endtask

    task automatic test_match();
        set_pw(8'hA5, 3);
        attempt(8'hA5, 1'b1, "match_ok");
        expect_fc(2'd0, "match_ok");
        expect_lock(1'b0, "match_ok");
    endtask

    task automatic test_lockout();
        attempt(8'h3C, 1'b0, "lock_f1");
        expect_fc(2'd1, "lock_f1");
        attempt(8'h3C, 1'b0, "lock_f2");
        expect_fc(2'd2, "lock_f2");
        attempt(8'h3C, 1'b0, "lock_f3");
        expect_fc(2'd3, "lock_sat");
        for (int i = 0; i < LOCKOUT_CYCLES; i++) begin
            expect_lock(1'b1, "lock_window");
            step();
        end
        expect_lock(1'b0, "lock_end");
        expect_fc(2'd0, "lock_end");
    endtask

    task automatic test_lockout_mask();
        for (int i = 0; i < MAX_FAILS; i++) attempt(8'h3C, 1'b0, "mask_fail");
        expect_lock(1'b1, "mask_start");
        CODE_IN = 8'hA5;
        saveAT  = 1'b1;
        step();
        expect_match(1'b0, "mask_c1");
        expect_fc(2'd3, "mask_c1");
        step();
        expect_match(1'b0, "mask_c2");
        saveAT = 1'b0;
        step();
        expect_match(1'b0, "mask_c3");
        expect_fc(2'd3, "mask_c3");
        step();
        expect_lock(1'b1, "mask_c4");
        step();
        expect_lock(1'b0, "mask_end");
        expect_fc(2'd0, "mask_end");
        attempt(8'hA5, 1'b1, "mask_after");
        expect_fc(2'd0, "mask_after");
    endtask

    task automatic test_success_clears();
        attempt(8'h3C, 1'b0, "clr_f1");
        attempt(8'h5A, 1'b0, "clr_f2");
        expect_fc(2'd2, "clr_two");
        attempt(8'hA5, 1'b1, "clr_ok");
        expect_fc(2'd0, "clr_ok");
        attempt(8'h3C, 1'b0, "clr_f3");
        attempt(8'h3C, 1'b0, "clr_f4");
        expect_fc(2'd2, "clr_again");
        expect_lock(1'b0, "clr_again");
        set_pw(8'h77, 1);
        expect_fc(2'd2, "rekey_keeps");
        expect_match(1'b0, "rekey_mismatch");
        attempt(8'h77, 1'b1, "rekey_ok");
        expect_fc(2'd0, "rekey_ok");
    endtask

    task automatic test_reset_abort();
        set_pw(8'hA5, 1);
        for (int i = 0; i < MAX_FAILS; i++) attempt(8'h3C, 1'b0, "abort_fail");
        expect_lock(1'b1, "abort_l1");
        step();
        expect_lock(1'b1, "abort_l2");
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        expect_lock(1'b0, "abort_rst");
        expect_fc(2'd0, "abort_rst");
        expect_match(1'b0, "abort_rst");
        attempt(8'h00, 1'b0, "abort_nopw");
        expect_fc(2'd1, "abort_nopw");
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        RESET    = 1'b1;
        CODE_IN  = '0;
        savePW   = 1'b0;
        saveAT   = 1'b0;
        test_reset();
        test_match();
        test_lockout();
        test_lockout_mask();
        test_success_clears();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
